str_fifo: RTL and testbench

- Synthesizable AXI4-Stream buffer with a subordinate (s_) port on the input and a manager (m_) port on the output.
- Sits between a stream source and a stream drain: decouples backpressure and holds up to DEPTH beats.
- Carries tdata plus tlast.
- Provides the registered-ready endpoint that the bench source and drain models connect to from both sides.

---
 rtl/str_fifo.sv | 122 ++++++++++++
 tb/tb_str_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/str_fifo.sv
// str_fifo: AXI4-Stream buffer holding up to DEPTH beats of {tlast, tdata}.
// Decouples a stream source (s_ port) from a stream drain (m_ port).
// s_tready, m_tvalid, m_tdata and m_tlast all come straight from flops.
//
// Optional build macro: STR_FIFO_PKT_EN
//   Undefined: cut-through; m_tvalid whenever the FIFO holds a beat.
//   Defined:   store-and-forward; m_tvalid waits for a complete packet
//              (a buffered tlast) unless the FIFO is full.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   s_tvalid  / s_tready / s_tdata / s_tlast   input stream
//   m_tvalid  / m_tready / m_tdata / m_tlast   output stream
//   count     current occupancy, 0..DEPTH
module str_fifo #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tlast,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tlast,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DW:0]   mem_q [DEPTH];
  logic [DW:0]   mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          s_tready_q, s_tready_d;
  logic          m_tvalid_q, m_tvalid_d;
  logic [DW-1:0] m_tdata_q, m_tdata_d;
  logic          m_tlast_q, m_tlast_d;
  logic          push, pop;
  logic [AW:0]   count_after_pop;
`ifdef STR_FIFO_PKT_EN
  logic [AW:0]   pkt_cnt_q, pkt_cnt_d;
`endif

  always_comb begin
    push = s_tvalid & s_tready_q;
    pop  = m_tvalid_q & m_tready;

    mem_d = mem_q;
    if (push) mem_d[wptr_q] = {s_tlast, s_tdata};

    wptr_d          = wptr_q + AW'(push);
    rptr_d          = rptr_q + AW'(pop);
    count_after_pop = count_q - (AW+1)'(pop);
    count_d         = count_after_pop + (AW+1)'(push);
    s_tready_d      = (count_d != FULL);

    // Output register always tracks the head entry. When the FIFO drains to
    // empty on this edge and a beat arrives, that beat becomes the head and
    // has not reached storage yet, so take it straight from the input.
    if (push && (count_after_pop == '0)) begin
      m_tdata_d = s_tdata;
      m_tlast_d = s_tlast;
    end else begin
      {m_tlast_d, m_tdata_d} = mem_q[rptr_d];
    end

`ifdef STR_FIFO_PKT_EN
    pkt_cnt_d = pkt_cnt_q + (AW+1)'(push & s_tlast) - (AW+1)'(pop & m_tlast_q);
    // Full override lets packets longer than DEPTH flow cut-through; the
    // last term keeps an already-offered beat valid until it is taken.
    m_tvalid_d = (count_d != '0) &&
                 ((pkt_cnt_d != '0) || (count_d == FULL) || (m_tvalid_q && !pop));
`else
    m_tvalid_d = (count_d != '0);
`endif
  end

  // Storage: no reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
`ifdef STR_FIFO_PKT_EN
      pkt_cnt_q  <= '0;
`endif
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
`ifdef STR_FIFO_PKT_EN
      pkt_cnt_q  <= pkt_cnt_d;
`endif
    end
  end

  assign s_tready = s_tready_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tlast  = m_tlast_q;
  assign count    = count_q;

endmodule

// File: tb/tb_str_fifo.sv
// Testbench for str_fifo: vector tables, hand-written corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_str_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;

  str_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [31:0] d;
    logic        sl;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic [31:0] e_d;
    logic        e_ml;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, then sample just after the rising edge.
  task automatic drive(input logic sv, input logic [31:0] d, input logic sl, input logic mr);
    @(negedge clk);
    s_tvalid = sv; s_tdata = d; s_tlast = sl; m_tready = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hBAD; s_tlast = 1'b1; m_tready = 1'b0;
    #1;
    chk("rst_sready", s_tready, 0);
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_count",  count, 0);
    chk("rst_mdata",  m_tdata, 0);
    chk("rst_mlast",  m_tlast, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_sready", s_tready, 1);
    chk("rel_count",  count, 0);
    chk("rel_mvalid", m_tvalid, 0);
  endtask

  task automatic run_table();
    foreach (vt[i]) begin
      drive(vt[i].sv, vt[i].d, vt[i].sl, vt[i].mr);
      chk($sformatf("tbl%0d_sready", i), s_tready, vt[i].e_sr);
      chk($sformatf("tbl%0d_mvalid", i), m_tvalid, vt[i].e_mv);
      chk($sformatf("tbl%0d_count", i),  count,    vt[i].e_cnt);
      if (vt[i].e_mv) begin
        chk($sformatf("tbl%0d_mdata", i), m_tdata, vt[i].e_d);
        chk($sformatf("tbl%0d_mlast", i), m_tlast, vt[i].e_ml);
      end
    end
    vt.delete();
  endtask

  initial begin
    logic [32:0] q[$];
    logic [31:0] got[$];
    logic        exp_sr, exp_mv, sv, sl, mr, push, pop, seen;
    logic [31:0] d;
    int          npk, idx, cyc;

    do_reset();

`ifndef STR_FIFO_PKT_EN
    // Single beat, then fill / backpressure / drain.
    vt.push_back('{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 3'd1});
    vt.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0});
    vt.push_back('{1'b1, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1, 1'b0, 3'd1});
    vt.push_back('{1'b1, 32'h2, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1, 1'b0, 3'd2});
    vt.push_back('{1'b1, 32'h3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1, 1'b0, 3'd3});
    vt.push_back('{1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 1'b0, 3'd4});
    vt.push_back('{1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 1'b0, 3'd4});
    vt.push_back('{1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2, 1'b0, 3'd3});
    vt.push_back('{1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2, 1'b0, 3'd4});
    vt.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3, 1'b0, 3'd3});
    vt.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4, 1'b0, 3'd2});
    vt.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5, 1'b0, 3'd1});
    vt.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0});
    run_table();
`else
    // Packet held back until its tlast arrives.
    vt.push_back('{1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 3'd1});
    vt.push_back('{1'b1, 32'hB, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 3'd2});
    vt.push_back('{1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA, 1'b0, 3'd3});
    vt.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB, 1'b0, 3'd2});
    vt.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hC, 1'b1, 3'd1});
    vt.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0});
    run_table();

    // Packet longer than DEPTH: forwarding must start once full.
    idx = 0; seen = 1'b0; got.delete();
    for (cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
      @(negedge clk);
      if (m_tvalid) got.push_back(m_tdata);  // m_tready is 1 throughout
      if (s_tvalid && s_tready) idx++;
      s_tvalid = (idx < 6); s_tdata = 32'h50 + idx; s_tlast = (idx == 5); m_tready = 1'b1;
      @(posedge clk);
      #1;
      if (m_tvalid && !seen) begin
        seen = 1'b1;
        chk("long_first_count", count, 4);
      end
    end
    chk("long_drained", got.size(), 6);
    foreach (got[i]) chk($sformatf("long_order%0d", i), got[i], 32'h50 + i);
`endif

    // Streaming: one beat per cycle with count steady at 1.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h100 + i, 1'b1, 1'b1);
      chk($sformatf("strm%0d_mvalid", i), m_tvalid, 1);
      chk($sformatf("strm%0d_count", i),  count, 1);
      chk($sformatf("strm%0d_mdata", i),  m_tdata, 32'h100 + i);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("strm_end_count", count, 0);

    // Reset mid-operation.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h200 + i, 1'b1, 1'b0);
    chk("mid_pre_count", count, 3);
    @(negedge clk);
    rst = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
    #1;
    chk("mid_mvalid", m_tvalid, 0);
    chk("mid_count",  count, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      chk($sformatf("mid_post%0d_mvalid", i), m_tvalid, 0);
    end
    chk("mid_post_sready", s_tready, 1);

    // Randomized traffic against a queue model.
    q.delete(); exp_sr = 1'b1; exp_mv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      sv = 1'($urandom_range(0, 1));
      mr = 1'($urandom_range(0, 2) != 0);
      sl = 1'($urandom_range(0, 2) == 0);
      d  = $urandom;
      push = sv && exp_sr;
      pop  = mr && exp_mv;
      drive(sv, d, sl, mr);
      if (pop) void'(q.pop_front());
      if (push) q.push_back({sl, d});
      exp_sr = (q.size() != DEPTH);
`ifdef STR_FIFO_PKT_EN
      npk = 0;
      foreach (q[k]) if (q[k][32]) npk++;
      exp_mv = (q.size() != 0) && (npk != 0 || q.size() == DEPTH || (exp_mv && !pop));
`else
      npk = 0;
      exp_mv = (q.size() != 0);
`endif
      chk("rnd_sready", s_tready, exp_sr);
      chk("rnd_mvalid", m_tvalid, exp_mv);
      chk("rnd_count",  count, q.size());
      if (exp_mv) begin
        chk("rnd_mdata", m_tdata, q[0][31:0]);
        chk("rnd_mlast", m_tlast, q[0][32]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
